bin_frame_packer: RTL and testbench
===================================

// Module: bin_frame_packer
// PURPOSE
// - Transmit side of the 7-bin magnitude interface consumed by the peak-index stage of the tuner.
// - Takes bin magnitudes one per beat, in order, from the per-bin energy path and packs them into a full frame.
// - Presents the frame as data_o[NUM_BINS] with valid/ready.
// - Holds data_o stable after the handshake so the multi-cycle downstream compare still reads valid data.
// PARAMETERS
// - NUM_BINS     7    bins per frame; index range 0..NUM_BINS-1
// - WIDTH        16   bits per bin magnitude
// - HOLD_CYCLES  4    min cycles data_o stays frozen after output handshake (>=3; downstream compare depth)
// - NOISE_FLOOR  256  threshold used only when NOISE_FLOOR_EN is defined
// PORTS
// - clk_i    in   1                 clock, all logic on rising edge
// - reset_i  in   1                 synchronous active-high reset
// - valid_i  in   1                 input beat valid
// - ready_o  out  1                 packer can accept a beat
// - data_i   in   WIDTH             magnitude of current bin
// - last_i   in   1                 marks final bin of a frame
// - data_o   out  WIDTH x NUM_BINS  packed frame (unpacked array [NUM_BINS-1:0])
// - valid_o  out  1                 frame valid
// - ready_i  in   1                 downstream accepts frame
// - err_o    out  1                 1-cycle pulse: framing error, frame dropped
// BEHAVIOUR
// - Reset: ready_o=1 from the first cycle after reset; valid_o=0, err_o=0, data_o=all 0, bin count=0, hold count=0.
// - Input FSM:
//   - COLLECT: each valid_i&&ready_o beat writes data_i to buf[cnt] and increments cnt.
//   - If last_i and cnt==NUM_BINS-1: go to FULL.
//   - ready_o = (state==COLLECT).
// - Framing errors:
//   - last_i with cnt<NUM_BINS-1, or cnt==NUM_BINS-1 without last_i.
//   - Frame discarded, cnt<=0, err_o=1 next cycle, stay in COLLECT.
//   - Offending beat is consumed, not restarted.
// - FULL: ready_o=0. Loads buf into data_o when the output slot is EMPTY, then returns to COLLECT (cnt=0). Load takes 1 cycle.
// - Output FSM:
//   - EMPTY -> VALID on load (valid_o=1 next cycle).
//   - VALID: data_o, valid_o stable until valid_i... ready_i; handshake is valid_o&&ready_i.
//   - Handshake -> HOLD: valid_o=0, hold counter=HOLD_CYCLES.
//   - HOLD decrements; ->EMPTY at 0. data_o never changes in VALID or HOLD.
// - Latency: last beat accepted in cycle N -> valid_o=1 in N+2 if output slot EMPTY.
// - Simultaneous events:
//   - Load and last beat in the same cycle cannot occur (ready_o=0 in FULL).
//   - Handshake while buf FULL: load waits HOLD_CYCLES+1 cycles.
// - No wrap: cnt saturates by framing rule; never exceeds NUM_BINS-1.
// - Reset mid-frame or mid-hold: all state returns to reset values next cycle.
//   - Partial buffer discarded; no err_o pulse.
// - Widths: buffer and data_o are WIDTH bits, unsigned; no arithmetic on data other than the floor compare.
// CONFIGURATION
// - NOISE_FLOOR_EN defined: beats with data_i < NOISE_FLOOR (unsigned) are stored as 0; data_i >= NOISE_FLOOR stored unchanged.
// - NOISE_FLOOR_EN undefined: data_i stored unchanged; NOISE_FLOOR parameter ignored.
// TESTING
// - T1 7 beats 10,20,..,70, last on 7th, ready_i=1 -> valid_o 2 cycles after last; data_o[0..6]=10..70; handshake; ready_o=1.
// - T2 ready_i=0 for 20 cycles after frame -> valid_o, data_o stable; second frame stalls in FULL with ready_o=0; loads HOLD_CYCLES+1 after handshake.
// - T3 last_i on 4th beat -> err_o=1 for 1 cycle, no valid_o; next 7-beat frame delivered correctly.
// - T4 7 beats, no last_i on 7th -> err_o pulse, frame dropped, cnt=0.
// - T5 reset_i pulse after 3 beats -> no err_o, valid_o=0, ready_o=1; next full frame correct.
// - T6 NOISE_FLOOR_EN, beats 255,256,1000,0,300,100,256 -> data_o=0,256,1000,0,300,0,256; undefined -> unchanged.

Source files
------------

// File: rtl/bin_frame_packer.sv
// Packs NUM_BINS magnitude beats into one frame and presents it with valid/ready,
// freezing data_o for HOLD_CYCLES after the output handshake. Optional macro: NOISE_FLOOR_EN.
module bin_frame_packer #(
  parameter int NUM_BINS    = 7,
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int NOISE_FLOOR = 256
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic [WIDTH-1:0] data_o [NUM_BINS-1:0],
  output logic             valid_o,
  input  logic             ready_i,
  output logic             err_o
);

  localparam int CW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BINS - 1);
`ifdef NOISE_FLOOR_EN
  localparam bit FLOOR_EN = 1'b1;
`else
  localparam bit FLOOR_EN = 1'b0;
`endif

  typedef enum logic {
    IN_COLLECT,
    IN_FULL
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_EMPTY,
    OUT_VALID,
    OUT_HOLD
  } out_state_t;

  in_state_t        in_q, in_d;
  out_state_t       out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bins_q [NUM_BINS-1:0];
  logic [WIDTH-1:0] bins_d [NUM_BINS-1:0];
  logic [WIDTH-1:0] data_q [NUM_BINS-1:0];
  logic [WIDTH-1:0] data_d [NUM_BINS-1:0];
  logic [WIDTH-1:0] store_val;
  logic             beat;
  logic             load;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_q   <= IN_COLLECT;
      out_q  <= OUT_EMPTY;
      cnt_q  <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
      bins_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      in_q   <= in_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      err_q  <= err_d;
      bins_q <= bins_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    in_d   = in_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    err_d  = 1'b0;
    bins_d = bins_q;
    data_d = data_q;

    store_val = (FLOOR_EN && (data_i < WIDTH'(NOISE_FLOOR))) ? '0 : data_i;
    beat = valid_i && (in_q == IN_COLLECT);
    load = (in_q == IN_FULL) && (out_q == OUT_EMPTY);

    // Any mismatch between last_i and the bin position drops the frame; the beat is consumed.
    if (beat) begin
      bins_d[cnt_q] = store_val;
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
        if (last_i) in_d = IN_FULL;
        else        err_d = 1'b1;
      end else if (last_i) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (out_q)
      OUT_EMPTY: begin
        if (load) begin
          data_d = bins_q;
          out_d  = OUT_VALID;
          in_d   = IN_COLLECT;
        end
      end
      OUT_VALID: begin
        if (ready_i) begin
          out_d  = OUT_HOLD;
          hold_d = HW'(HOLD_CYCLES);
        end
      end
      OUT_HOLD: begin
        if (hold_q <= HW'(1)) begin
          out_d  = OUT_EMPTY;
          hold_d = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: out_d = OUT_EMPTY;
    endcase
  end

  assign ready_o = (in_q == IN_COLLECT);
  assign valid_o = (out_q == OUT_VALID);
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_bin_frame_packer.sv
// Directed self-checking bench for bin_frame_packer (build with +define+NOISE_FLOOR_EN for the floor variant).
module tb_bin_frame_packer;

  logic        clk = 1'b0;
  logic        reset_i, valid_i, last_i, ready_i;
  logic [15:0] data_i;
  logic        ready_o, valid_o, err_o;
  logic [15:0] data_o [6:0];

  int checks = 0;
  int failures = 0;

  logic [15:0] f1 [7];
  logic [15:0] f2 [7];
  logic [15:0] fexp [7];

  bin_frame_packer #(.NUM_BINS(7), .WIDTH(16), .HOLD_CYCLES(4), .NOISE_FLOOR(256)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .last_i(last_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input logic [15:0] v [7], input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b1;
      data_i  = v[i];
      last_i  = (i == last_at);
      tick(1);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] v [7]);
    for (int i = 0; i < 7; i++) chk($sformatf("%s[%0d]", tag, i), data_o[i], v[i]);
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0; data_i = '0;
    tick(1);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    tick(1);
    reset_i = 1'b0;
    for (int i = 0; i < 7; i++) f1[i] = '0;
    chk_frame("rst_data", f1);

    // T1: basic frame, latency two cycles after last beat
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) f1[i] = 16'(10 * (i + 1));
    send_beats(f1, 7, 6);
    chk("t1_valid_n1", valid_o, 0);
    chk("t1_ready_full", ready_o, 0);
    tick(1);
    chk("t1_valid_n2", valid_o, 1);
    chk("t1_ready_back", ready_o, 1);
    chk_frame("t1_data", f1);
    tick(1);
    chk("t1_valid_after_hs", valid_o, 0);
    chk_frame("t1_hold_data", f1);
    tick(6);

    // T2: downstream stall; second frame waits in FULL
    ready_i = 1'b0;
    for (int i = 0; i < 7; i++) f1[i] = 16'h1001 + 16'(i);
    for (int i = 0; i < 7; i++) f2[i] = 16'h2001 + 16'(i);
    send_beats(f1, 7, 6);
    tick(1);
    chk("t2_valid", valid_o, 1);
    send_beats(f2, 7, 6);
    chk("t2_stall_ready", ready_o, 0);
    chk("t2_stall_valid", valid_o, 1);
    chk_frame("t2_stall_data", f1);
    tick(12);
    chk("t2_stall20_valid", valid_o, 1);
    chk("t2_stall20_ready", ready_o, 0);
    chk_frame("t2_stall20_data", f1);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    chk("t2_hs_valid", valid_o, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("t2_hold%0d_valid", k), valid_o, 0);
      chk($sformatf("t2_hold%0d_data0", k), data_o[0], f1[0]);
    end
    tick(1);
    chk("t2_load_valid", valid_o, 1);
    chk("t2_load_ready", ready_o, 1);
    chk_frame("t2_load_data", f2);
    ready_i = 1'b1;
    tick(7);

    // T3: early last on 4th beat
    send_beats(f2, 4, 3);
    chk("t3_err", err_o, 1);
    chk("t3_ready", ready_o, 1);
    chk("t3_valid", valid_o, 0);
    tick(1);
    chk("t3_err_pulse", err_o, 0);
    chk("t3_valid2", valid_o, 0);
    for (int i = 0; i < 7; i++) f1[i] = 16'h3000 + 16'(7 * i);
    send_beats(f1, 7, 6);
    tick(1);
    chk("t3_next_valid", valid_o, 1);
    chk_frame("t3_next_data", f1);
    tick(7);

    // T4: 7 beats without last
    send_beats(f2, 7, -1);
    chk("t4_err", err_o, 1);
    chk("t4_ready", ready_o, 1);
    chk("t4_valid", valid_o, 0);
    tick(1);
    chk("t4_err_pulse", err_o, 0);
    chk("t4_no_valid", valid_o, 0);
    send_beats(f2, 7, 6);
    chk("t4_next_err", err_o, 0);
    tick(1);
    chk("t4_next_valid", valid_o, 1);
    chk_frame("t4_next_data", f2);
    tick(7);

    // T5: reset mid-frame
    send_beats(f1, 3, -1);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    chk("t5_err", err_o, 0);
    chk("t5_valid", valid_o, 0);
    chk("t5_ready", ready_o, 1);
    tick(1);
    chk("t5_err2", err_o, 0);
    send_beats(f2, 7, 6);
    tick(1);
    chk("t5_next_valid", valid_o, 1);
    chk_frame("t5_next_data", f2);
    tick(7);

    // T6: noise floor boundary values
    f1 = '{16'd255, 16'd256, 16'd1000, 16'd0, 16'd300, 16'd100, 16'd256};
`ifdef NOISE_FLOOR_EN
    fexp = '{16'd0, 16'd256, 16'd1000, 16'd0, 16'd300, 16'd0, 16'd256};
`else
    fexp = '{16'd255, 16'd256, 16'd1000, 16'd0, 16'd300, 16'd100, 16'd256};
`endif
    send_beats(f1, 7, 6);
    tick(1);
    chk("t6_valid", valid_o, 1);
    chk_frame("t6_data", fexp);
    tick(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
